// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU issue sequencer: opcode set, flag bit positions,
// FSM encoding, condition codes and the latched request record.
package alu_sequencer_pkg;

   localparam int SEQ_NREGS = 8;
   localparam int SEQ_W     = 16;
   localparam int SEQ_AW    = 3;
   localparam int OPC_W     = 5;
   localparam int FLAG_W    = 4;

   localparam logic [OPC_W-1:0] OP_NOP = 5'd0;
   localparam logic [OPC_W-1:0] OP_ADD = 5'd1;
   localparam logic [OPC_W-1:0] OP_SUB = 5'd2;
   localparam logic [OPC_W-1:0] OP_AND = 5'd3;
   localparam logic [OPC_W-1:0] OP_OR  = 5'd4;
   localparam logic [OPC_W-1:0] OP_XOR = 5'd5;
   localparam logic [OPC_W-1:0] OP_NOT = 5'd6;
   localparam logic [OPC_W-1:0] OP_SHL = 5'd7;
   localparam logic [OPC_W-1:0] OP_SHR = 5'd8;
   localparam logic [OPC_W-1:0] OP_MUL = 5'd9;
   localparam logic [OPC_W-1:0] OP_DIV = 5'd10;
   localparam logic [OPC_W-1:0] OP_CMP = 5'd11;
   localparam logic [OPC_W-1:0] OP_TST = 5'd12;
   localparam logic [OPC_W-1:0] OP_MOV = 5'd13;
   localparam logic [OPC_W-1:0] OP_INC = 5'd14;
   localparam logic [OPC_W-1:0] OP_DEC = 5'd15;
   localparam logic [OPC_W-1:0] OP_LAST = OP_DEC;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_O = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } seq_state_e;

   typedef enum logic [2:0] {
      CC_EQ = 3'd0,
      CC_NE = 3'd1,
      CC_MI = 3'd2,
      CC_PL = 3'd3,
      CC_CS = 3'd4,
      CC_CC = 3'd5,
      CC_VS = 3'd6,
      CC_AL = 3'd7
   } cond_e;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [SEQ_AW-1:0] rd;
      logic [SEQ_AW-1:0] ra;
      logic [SEQ_AW-1:0] rb;
      logic              imm_sel;
      logic [SEQ_W-1:0]  imm;
   } seq_req_t;

   // Anything outside the shared set behaves as NOP.
   function automatic logic op_known(input logic [OPC_W-1:0] op);
      return op <= OP_LAST;
   endfunction

   function automatic logic op_writes_rd(input logic [OPC_W-1:0] op);
      return op_known(op) && op != OP_NOP && op != OP_CMP && op != OP_TST;
   endfunction

   function automatic logic op_writes_flags(input logic [OPC_W-1:0] op);
      return op_known(op) && op != OP_NOP && op != OP_TST;
   endfunction

   function automatic logic cond_eval(input cond_e cc, input logic [FLAG_W-1:0] f);
      logic r;
      r = 1'b1;
      case (cc)
         CC_EQ: r = f[FLAG_Z];
         CC_NE: r = !f[FLAG_Z];
         CC_MI: r = f[FLAG_N];
         CC_PL: r = !f[FLAG_N];
         CC_CS: r = f[FLAG_C];
         CC_CC: r = !f[FLAG_C];
         CC_VS: r = f[FLAG_O];
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request channel from the control unit into the ALU sequencer (valid/ready plus fields).
interface alu_sequencer_if;
   import alu_sequencer_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic [OPC_W-1:0]      req_opcode;
   logic [SEQ_AW-1:0]     req_rd;
   logic [SEQ_AW-1:0]     req_ra;
   logic [SEQ_AW-1:0]     req_rb;
   logic                  req_imm_sel;
   logic [SEQ_W-1:0]      req_imm;

   modport master (
      output req_valid, req_opcode, req_rd, req_ra, req_rb, req_imm_sel, req_imm,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_opcode, req_rd, req_ra, req_rb, req_imm_sel, req_imm,
      output req_ready
   );
endinterface

// File: rtl/alu_seq_regfile.sv
// 8x16 register file: one synchronous write port, two operand read ports and a
// debug read port, all reads combinational; synchronous reset clears every entry.
module alu_seq_regfile #(
   parameter int NREGS = 8,
   parameter int W     = 16,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] a_addr,
   output logic [W-1:0]  a_data,
   input  logic [AW-1:0] b_addr,
   output logic [W-1:0]  b_data,
   input  logic [AW-1:0] dbg_addr,
   output logic [W-1:0]  dbg_data
);

   logic [NREGS-1:0][W-1:0] mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign a_data   = mem[a_addr];
   assign b_data   = mem[b_addr];
   assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state issue controller for the external combinational ALU.
// Optional ALU_SEQ_COND_EN adds cond_sel/cond_true condition evaluation on flags_q.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int NREGS = SEQ_NREGS,
   parameter int W     = SEQ_W,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   alu_sequencer_if.slave      req,
   output logic                busy,
   output logic                done,
   output logic [FLAG_W-1:0]   flags_q,
   output logic [W-1:0]        alu_a,
   output logic [W-1:0]        alu_b,
   output logic [OPC_W-1:0]    alu_opcode,
   output logic                alu_enable,
   input  logic [W-1:0]        alu_result,
   input  logic [FLAG_W-1:0]   alu_flags,
   input  logic [AW-1:0]       dbg_addr,
   output logic [W-1:0]        dbg_data
`ifdef ALU_SEQ_COND_EN
   ,
   input  logic [2:0]          cond_sel,
   output logic                cond_true
`endif
);

   seq_state_e        state_q, state_d;
   seq_req_t          req_q;
   logic [W-1:0]      res_q;
   logic [FLAG_W-1:0] cap_flags_q;
   logic [W-1:0]      a_data, b_data;
   logic              accept;
   logic              rf_we;
   logic              ready;

   alu_seq_regfile #(
      .NREGS (NREGS),
      .W     (W),
      .AW    (AW)
   ) u_rf (
      .clk      (clk),
      .rst      (rst),
      .we       (rf_we),
      .waddr    (req_q.rd),
      .wdata    (res_q),
      .a_addr   (req_q.ra),
      .a_data   (a_data),
      .b_addr   (req_q.rb),
      .b_data   (b_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_opcode  <= '0;
         res_q       <= '0;
         cap_flags_q <= '0;
         flags_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            req_q <= '{opcode:  req.req_opcode,
                       rd:      req.req_rd,
                       ra:      req.req_ra,
                       rb:      req.req_rb,
                       imm_sel: req.req_imm_sel,
                       imm:     req.req_imm};
         end
         if (state_q == ST_READ) begin
            alu_a      <= a_data;
            alu_b      <= req_q.imm_sel ? req_q.imm : b_data;
            alu_opcode <= req_q.opcode;
         end
         // ALU outputs are stable one cycle after the operand registers load.
         if (state_q == ST_EXEC) begin
            res_q       <= alu_result;
            cap_flags_q <= alu_flags;
         end
         if (state_q == ST_WB && op_writes_flags(req_q.opcode)) begin
            flags_q <= cap_flags_q;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ready      = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      alu_enable = 1'b0;
      accept     = 1'b0;
      rf_we      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready = 1'b1;
            busy  = 1'b0;
            if (req.req_valid) begin
               accept  = 1'b1;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            alu_enable = 1'b1;
            state_d    = ST_EXEC;
         end
         ST_EXEC: begin
            alu_enable = 1'b1;
            state_d    = ST_WB;
         end
         ST_WB: begin
            done    = 1'b1;
            rf_we   = op_writes_rd(req_q.opcode);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign req.req_ready = ready;

`ifdef ALU_SEQ_COND_EN
   assign cond_true = cond_eval(cond_e'(cond_sel), flags_q);
`endif

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue controller driving the combinational ALU from the initiating side. Accepts one operation per valid/ready handshake, reads operands from an internal 8x16 register file (or immediate), presents them to the ALU, captures Result/flags, writes back and holds a 4-bit flag register. Sits between the control unit and the ALU in the 16-bit datapath.

## Interface
- NREGS, 8, register-file depth (address width 3)
- W, 16, datapath width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept (high only in IDLE)
- req_opcode  in  5  ALU opcode (shared opcode constants)
- req_rd / req_ra / req_rb  in  3 each  destination, source A, source B
- req_imm_sel  in  1  1: B operand = req_imm
- req_imm  in  16  immediate
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse in WB
- flags_q  out  4  flag register {Z,N,C,O} = bits [3:0]
- alu_a, alu_b  out  16  registered ALU operands
- alu_opcode  out  5  registered opcode
- alu_enable  out  1  high in READ and EXEC
- alu_result  in  16  ALU Result
- alu_flags  in  4  ALU flags {Z,N,C,O}
- dbg_addr  in  3, dbg_data  out  16  combinational register-file read

## Operation
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE; no other transitions except reset.
- IDLE: req_ready=1. On req_valid&&req_ready latch opcode, rd, ra, rb, imm_sel, imm; go READ.
- READ: alu_a <= rf[ra]; alu_b <= imm_sel ? imm : rf[rb]; alu_opcode <= latched opcode; go EXEC.
- EXEC: ALU settles; capture alu_result, alu_flags into holding regs; go WB.
- WB: done=1. rf[rd] <= result unless opcode is CMP, TST or NOP. flags_q <= captured flags unless opcode is TST or NOP. Go IDLE.
- Opcodes outside the shared set: treated as NOP (no write, no flag update, done still pulses).
- All 8 registers general purpose (r0 writable).
- Sequencer never modifies ALU values: div-by-zero 0xFFFF/O, overflow etc. pass through unchanged.

## Timing
- Reset: state=IDLE, all rf entries 0, flags_q=0, alu_a=alu_b=0, alu_opcode=0, alu_enable=0, done=0, busy=0, req_ready=1 on the cycle after rst sampled high.
- Handshake at edge N -> READ N+1, EXEC N+2, WB/done N+3, req_ready high again N+4. Throughput 1 op / 4 cycles.
- req_valid held high: next op accepted at N+4; request fields ignored while busy.
- Write in WB at N+3 visible to a following op's READ (N+5) and to dbg_data from N+4.
- rd == ra/rb: operands read before write; no hazard.
- Reset mid-operation (any state): abort, no rf write, no done, all reset values apply.

## Configuration
- ALU_SEQ_COND_EN defined: adds input cond_sel[2:0] and output cond_true (combinational from flags_q): 0 EQ(Z), 1 NE(!Z), 2 MI(N), 3 PL(!N), 4 CS(C), 5 CC(!C), 6 VS(O), 7 AL(1).
- Undefined: cond_sel/cond_true ports absent; no other change.

## Structure
- Shared package: opcode constants (existing shared set), flag bit indices Z=3,N=2,C=1,O=0, FSM state encoding, condition codes.
- One sub-module natural: alu_seq_regfile (8x16, one sync write port, two comb read ports plus debug read port, sync reset to 0).
- ALU instantiated outside; this block only drives/consumes its ports.

## Test plan
- Reset then ADD r1 = r0 + imm 0x7FFF -> done at handshake+3, dbg r1 = 0x7FFF, flags_q = 4'b0000.
- ADD r2 = r1 + imm 0x0001 -> r2 = 0x8000, flags_q = 4'b0101 (N,O).
- CMP r1, imm 0x7FFF -> flags_q = 4'b1000, r1 still 0x7FFF, no register changed.
- DIV r3 = r1 / r0 (r0 = 0) -> r3 = 0xFFFF, flags_q O=1; then NOP -> flags_q unchanged, done pulses.
- req_valid held high for two ops -> second accepted exactly 4 cycles after first; busy high 3 cycles each.
- Assert rst in EXEC of SUB r4 = r1 - imm 1 -> r4 = 0, flags_q = 0, no done, req_ready=1 next cycle.
